// File: rtl/gpr_wb_arb_pkg.sv
// Shared GPR writeback types and widths.
// Imported by the arbiter, the GPR macro wrapper and the issue scoreboard.
package gpr_wb_arb_pkg;

    localparam int GPR_ADR_W = 5;
    localparam int GPR_DAT_W = 32;

    typedef struct packed {
        logic [GPR_ADR_W-1:0] adr;
        logic [GPR_DAT_W-1:0] dat;
    } wb_req_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

endpackage

// File: rtl/gpr_wb_arb_if.sv
// Writeback sources, GPR write/read ports and bypassed read data.
// slave = the arbiter, master = execution units plus GPR macro.
interface gpr_wb_arb_if #(
    parameter int ADR_W = 5,
    parameter int DAT_W = 32
);
    logic             s0_valid;
    logic             s0_ready;
    logic [ADR_W-1:0] s0_adr;
    logic [DAT_W-1:0] s0_dat;
    logic             s1_valid;
    logic             s1_ready;
    logic [ADR_W-1:0] s1_adr;
    logic [DAT_W-1:0] s1_dat;
    logic             gpr_wr_en;
    logic [ADR_W-1:0] gpr_wr_adr;
    logic [DAT_W-1:0] gpr_wr_dat;
    logic [ADR_W-1:0] rd_adr_0;
    logic [ADR_W-1:0] rd_adr_1;
    logic [ADR_W-1:0] rd_adr_2;
    logic [DAT_W-1:0] gpr_rd_dat_0;
    logic [DAT_W-1:0] gpr_rd_dat_1;
    logic [DAT_W-1:0] gpr_rd_dat_2;
    logic [DAT_W-1:0] rd_dat_0;
    logic [DAT_W-1:0] rd_dat_1;
    logic [DAT_W-1:0] rd_dat_2;
    logic             wb_idle;

    modport slave (
        input  s0_valid, s0_adr, s0_dat,
        input  s1_valid, s1_adr, s1_dat,
        input  rd_adr_0, rd_adr_1, rd_adr_2,
        input  gpr_rd_dat_0, gpr_rd_dat_1, gpr_rd_dat_2,
        output s0_ready, s1_ready,
        output gpr_wr_en, gpr_wr_adr, gpr_wr_dat,
        output rd_dat_0, rd_dat_1, rd_dat_2,
        output wb_idle
    );

    modport master (
        output s0_valid, s0_adr, s0_dat,
        output s1_valid, s1_adr, s1_dat,
        output rd_adr_0, rd_adr_1, rd_adr_2,
        output gpr_rd_dat_0, gpr_rd_dat_1, gpr_rd_dat_2,
        input  s0_ready, s1_ready,
        input  gpr_wr_en, gpr_wr_adr, gpr_wr_dat,
        input  rd_dat_0, rd_dat_1, rd_dat_2,
        input  wb_idle
    );

endinterface

// File: rtl/gpr_wb_fifo.sv
// Two-entry synchronous FIFO with occupancy count.
// Caller guarantees no push when full and no pop when empty.
module gpr_wb_fifo #(
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] dat_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   cnt_o
);

    logic [W-1:0] mem_q [2];
    logic         wp_q;
    logic         rp_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;

    // occupancy after this cycle's push/pop
    always_comb begin
        cnt_d = cnt_q;
        unique case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // pointers and count; reset drops all entries
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push_i) wp_q <= ~wp_q;
            if (pop_i)  rp_q <= ~rp_q;
            cnt_q <= cnt_d;
        end
    end

    // storage needs no reset; entries are only read when counted
    always_ff @(posedge clk) begin
        if (!reset && push_i) mem_q[wp_q] <= dat_i;
    end

    assign head_o = mem_q[rp_q];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/gpr_wb_arb.sv
// GPR writeback arbiter: merges ALU/LSU results into one write port
// and patches registered read data when read and write coincide.
module gpr_wb_arb
    import gpr_wb_arb_pkg::*;
#(
    parameter int ADR_W      = GPR_ADR_W,
    parameter int DAT_W      = GPR_DAT_W,
    parameter int FIFO_DEPTH = 2
) (
    input logic        clk,
    input logic        reset,
    gpr_wb_arb_if.slave bus
);

    localparam int         W     = ADR_W + DAT_W;
    localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

    logic [1:0]       cnt0, cnt1;
    logic [W-1:0]     head0, head1;
    logic             push0, push1;
    logic             pop0, pop1;
    src_e             ptr_q, ptr_d;
    logic             wr_en_q, wr_en_d;
    logic [ADR_W-1:0] wr_adr_q, wr_adr_d;
    logic [DAT_W-1:0] wr_dat_q, wr_dat_d;
    logic [2:0]       hit_q, hit_d;
    logic [DAT_W-1:0] byp_q;

    assign bus.s0_ready = !reset && (cnt0 < DEPTH);
    assign bus.s1_ready = !reset && (cnt1 < DEPTH);
    assign push0 = bus.s0_valid && bus.s0_ready;
    assign push1 = bus.s1_valid && bus.s1_ready;

    gpr_wb_fifo #(.W(W)) u_fifo0 (
        .clk    (clk),
        .reset  (reset),
        .push_i (push0),
        .pop_i  (pop0),
        .dat_i  ({bus.s0_adr, bus.s0_dat}),
        .head_o (head0),
        .cnt_o  (cnt0)
    );

    gpr_wb_fifo #(.W(W)) u_fifo1 (
        .clk    (clk),
        .reset  (reset),
        .push_i (push1),
        .pop_i  (pop1),
        .dat_i  ({bus.s1_adr, bus.s1_dat}),
        .head_o (head1),
        .cnt_o  (cnt1)
    );

    // round-robin grant; a lone non-empty source wins outright
    always_comb begin
        pop0  = 1'b0;
        pop1  = 1'b0;
        ptr_d = ptr_q;
        if (cnt1 != 2'd0 && (cnt0 == 2'd0 || ptr_q == SRC_LSU)) begin
            pop1  = 1'b1;
            ptr_d = SRC_ALU;
        end else if (cnt0 != 2'd0) begin
            pop0  = 1'b1;
            ptr_d = SRC_LSU;
        end
    end

    // write port next state; adr/dat hold when idle
    always_comb begin
        wr_en_d  = pop0 || pop1;
        wr_adr_d = wr_adr_q;
        wr_dat_d = wr_dat_q;
        if (pop1) begin
            wr_adr_d = head1[W-1:DAT_W];
            wr_dat_d = head1[DAT_W-1:0];
        end else if (pop0) begin
            wr_adr_d = head0[W-1:DAT_W];
            wr_dat_d = head0[DAT_W-1:0];
        end
    end

    // macro reads return pre-write data on a same-cycle write
    always_comb begin
        hit_d    = 3'b000;
        hit_d[0] = wr_en_q && (wr_adr_q == bus.rd_adr_0);
        hit_d[1] = wr_en_q && (wr_adr_q == bus.rd_adr_1);
        hit_d[2] = wr_en_q && (wr_adr_q == bus.rd_adr_2);
    end

    // pointer, write port and bypass registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= SRC_LSU;
            wr_en_q  <= 1'b0;
            wr_adr_q <= '0;
            wr_dat_q <= '0;
            hit_q    <= 3'b000;
            byp_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            wr_en_q  <= wr_en_d;
            wr_adr_q <= wr_adr_d;
            wr_dat_q <= wr_dat_d;
            hit_q    <= hit_d;
            byp_q    <= wr_dat_q;
        end
    end

    assign bus.gpr_wr_en  = wr_en_q;
    assign bus.gpr_wr_adr = wr_adr_q;
    assign bus.gpr_wr_dat = wr_dat_q;

    assign bus.rd_dat_0 = hit_q[0] ? byp_q : bus.gpr_rd_dat_0;
    assign bus.rd_dat_1 = hit_q[1] ? byp_q : bus.gpr_rd_dat_1;
    assign bus.rd_dat_2 = hit_q[2] ? byp_q : bus.gpr_rd_dat_2;

    assign bus.wb_idle = (cnt0 == 2'd0) && (cnt1 == 2'd0) && !wr_en_q;

endmodule
